// File: rtl/sf_tester_pattern_engine.sv
// Pattern generator/checker for the serial-flash tester: per-iteration byte stream,
// readback compare, address and page/subsector tracking. Optional LFSR pattern: SF_TESTER_PATTERN_LFSR_EN.
module sf_tester_pattern_engine #(
  parameter int unsigned PATTERN_COUNT    = 4,
  parameter int unsigned TOTAL_ITERATIONS = 32,
  parameter int unsigned MAX_BYTE_COUNT   = 33554432,
  parameter int unsigned PAGE_BYTES       = 256,
  parameter int unsigned SUBSECTOR_BYTES  = 4096,
`ifdef SF_TESTER_PATTERN_LFSR_EN
  localparam int unsigned NSEL  = PATTERN_COUNT + 1,
`else
  localparam int unsigned NSEL  = PATTERN_COUNT,
`endif
  localparam int unsigned SEL_W = $clog2(NSEL),
  localparam int unsigned AW    = $clog2(MAX_BYTE_COUNT),
  localparam int unsigned IW    = $clog2(TOTAL_ITERATIONS)
) (
  input  logic             i_clk_40mhz,
  input  logic             i_rst_40mhz,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [SEL_W-1:0] i_pattern_sel,
  input  logic             i_abort,
  output logic [7:0]       o_gen_data,
  output logic             o_gen_valid,
  input  logic             i_gen_ready,
  input  logic [7:0]       i_chk_data,
  input  logic             i_chk_valid,
  output logic [AW-1:0]    o_byte_addr,
  output logic [AW-1:0]    o_iter_start_addr,
  output logic             o_page_last,
  output logic             o_subsector_first,
  output logic [IW-1:0]    o_iter_idx,
  output logic [15:0]      o_err_count,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned PER_ITER = MAX_BYTE_COUNT / TOTAL_ITERATIONS;
  localparam int unsigned CW       = $clog2(PER_ITER);
  localparam int unsigned PW       = $clog2(PAGE_BYTES);
  localparam int unsigned SSW      = $clog2(SUBSECTOR_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_CHK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] pat_q, pat_d;
  logic [7:0]       exp_q, exp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [15:0]      err_q, err_d;

  logic             sel_in_range;
  logic [SEL_W-1:0] sel_eff;
  logic [7:0]       start_byte;
  logic [7:0]       next_byte;
  logic             xfer;
  logic             active;
  logic [AW-1:0]    iter_base;

  function automatic logic [7:0] pat_start(input logic [SEL_W-1:0] k);
    return 8'(k) << 3;
  endfunction

  function automatic logic [7:0] pat_incr(input logic [SEL_W-1:0] k);
    return (k == '0) ? 8'd1 : ((8'(k) << 3) - 8'd1);
  endfunction

  if (2 ** SEL_W > NSEL) begin : g_sel_range
    assign sel_in_range = (32'(i_pattern_sel) < NSEL);
  end else begin : g_sel_full
    assign sel_in_range = 1'b1;
  end

  assign sel_eff = sel_in_range ? i_pattern_sel : '0;

`ifdef SF_TESTER_PATTERN_LFSR_EN
  logic       lfsr_q, lfsr_d;
  logic [7:0] seed_raw;

  // XNOR feedback over the x^8+x^6+x^5+x^4 taps: A5 -> 4B -> 96 -> 2D.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
  endfunction

  assign seed_raw   = 8'hA5 ^ 8'(iter_q);
  assign start_byte = (sel_eff == SEL_W'(PATTERN_COUNT)) ?
                      ((seed_raw == 8'h00) ? 8'h01 : seed_raw) : pat_start(sel_eff);
  assign next_byte  = lfsr_q ? lfsr_next(exp_q) : (exp_q + pat_incr(pat_q));

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_IDLE && i_start && !i_abort)
      lfsr_d = (sel_eff == SEL_W'(PATTERN_COUNT));
  end

  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz) lfsr_q <= 1'b0;
    else             lfsr_q <= lfsr_d;
  end
`else
  assign start_byte = pat_start(sel_eff);
  assign next_byte  = exp_q + pat_incr(pat_q);
`endif

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    err_d   = err_q;
    xfer    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = i_mode ? S_CHK : S_GEN;
          pat_d   = sel_eff;
          exp_d   = start_byte;
          cnt_d   = '0;
          if (i_mode) err_d = '0;
        end
      end
      S_GEN: xfer = i_gen_ready;
      S_CHK: begin
        xfer = i_chk_valid;
        if (i_chk_valid && (i_chk_data != exp_q) && (err_q != '1))
          err_d = err_q + 16'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        iter_d  = iter_q + 1'b1;
      end
    endcase

    if (xfer) begin
      exp_d = next_byte;
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_DONE;
    end

    // Abort overrides everything computed above, including a same-cycle start.
    if (i_abort) begin
      state_d = S_IDLE;
      pat_d   = pat_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      iter_d  = iter_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  assign active    = (state_q == S_GEN) || (state_q == S_CHK);
  assign iter_base = {iter_q, {CW{1'b0}}};

  assign o_gen_data        = exp_q;
  assign o_gen_valid       = (state_q == S_GEN);
  assign o_iter_start_addr = iter_base;
  assign o_byte_addr       = active ? (iter_base + AW'(cnt_q)) : '0;
  assign o_page_last       = active && (&cnt_q[PW-1:0]);
  assign o_subsector_first = active && !(|cnt_q[SSW-1:0]);
  assign o_iter_idx        = iter_q;
  assign o_err_count       = err_q;
  assign o_busy            = (state_q != S_IDLE);
  assign o_done            = (state_q == S_DONE);

endmodule

// File: tb/tb_sf_tester_pattern_engine.sv
// Self-checking bench for sf_tester_pattern_engine against an arithmetic pattern model.
module tb_sf_tester_pattern_engine;

  localparam int unsigned PC  = 4;
  localparam int unsigned TI  = 4;
  localparam int unsigned MBC = 1024;
  localparam int unsigned PB  = 16;
  localparam int unsigned SB  = 64;
  localparam int unsigned PER = MBC / TI;
`ifdef SF_TESTER_PATTERN_LFSR_EN
  localparam int unsigned SEL_W = $clog2(PC + 1);
`else
  localparam int unsigned SEL_W = $clog2(PC);
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_mode, i_abort, i_gen_ready, i_chk_valid;
  logic [SEL_W-1:0] i_pattern_sel;
  logic [7:0]       i_chk_data;
  logic [7:0]       o_gen_data;
  logic             o_gen_valid, o_page_last, o_subsector_first, o_busy, o_done;
  logic [9:0]       o_byte_addr, o_iter_start_addr;
  logic [1:0]       o_iter_idx;
  logic [15:0]      o_err_count;

  int errors = 0;
  int checks = 0;
  int model_iter = 0;
  int model_err = 0;

  always #5 clk = ~clk;

  sf_tester_pattern_engine #(
    .PATTERN_COUNT(PC),
    .TOTAL_ITERATIONS(TI),
    .MAX_BYTE_COUNT(MBC),
    .PAGE_BYTES(PB),
    .SUBSECTOR_BYTES(SB)
  ) dut (
    .i_clk_40mhz(clk),
    .i_rst_40mhz(rst),
    .i_start(i_start),
    .i_mode(i_mode),
    .i_pattern_sel(i_pattern_sel),
    .i_abort(i_abort),
    .o_gen_data(o_gen_data),
    .o_gen_valid(o_gen_valid),
    .i_gen_ready(i_gen_ready),
    .i_chk_data(i_chk_data),
    .i_chk_valid(i_chk_valid),
    .o_byte_addr(o_byte_addr),
    .o_iter_start_addr(o_iter_start_addr),
    .o_page_last(o_page_last),
    .o_subsector_first(o_subsector_first),
    .o_iter_idx(o_iter_idx),
    .o_err_count(o_err_count),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  // Byte n of arithmetic pattern k: start 8k, step (k==0 ? 1 : 8k-1), all mod 256.
  function automatic logic [7:0] pat_byte(input int k, input int n);
    int st, inc;
    st  = (8 * k) % 256;
    inc = (k == 0) ? 1 : (8 * k - 1) % 256;
    return 8'((st + n * inc) % 256);
  endfunction

  task automatic start_run(input logic mode, input int sel);
    @(negedge clk);
    i_mode = mode;
    i_pattern_sel = SEL_W'(sel);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (mode) model_err = 0;
  endtask

  task automatic finish_iteration(input string tag);
    checks++;
    if (o_done !== 1'b1 || o_iter_idx !== 2'(model_iter)) begin
      errors++;
      $display("FAIL %s_done: done=%b iter=%0d want done=1 iter=%0d", tag, o_done, o_iter_idx, model_iter);
    end
    @(negedge clk);
    model_iter = (model_iter + 1) % TI;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_iter_idx !== 2'(model_iter)) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b iter=%0d want 0 0 %0d", tag, o_done, o_busy, o_iter_idx, model_iter);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_start = 0; i_mode = 0; i_pattern_sel = '0; i_abort = 0;
    i_gen_ready = 0; i_chk_valid = 0; i_chk_data = '0;
    #12;
    checks++;
    if ({o_gen_data, o_gen_valid, o_byte_addr, o_iter_start_addr, o_page_last, o_subsector_first,
         o_iter_idx, o_err_count, o_busy, o_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h valid=%b addr=%0d base=%0d pl=%b sf=%b iter=%0d err=%0d busy=%b done=%b want all 0",
               o_gen_data, o_gen_valid, o_byte_addr, o_iter_start_addr, o_page_last, o_subsector_first,
               o_iter_idx, o_err_count, o_busy, o_done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", o_busy);
    end
  endtask

  // ready_policy: 0 = always, 1 = toggle 1/0, 2 = random
  task automatic test_gen(input int sel, input int ready_policy);
    int n, cyc;
    logic rdy, prev_rdy;
    logic [7:0] prev_data;
    string tag;
    tag = $sformatf("gen_p%0d_r%0d", sel, ready_policy);
    start_run(1'b0, sel);
    n = 0; cyc = 0; prev_rdy = 1'b1; prev_data = '0;
    while (n < PER && cyc < PER * 8) begin
      rdy = (ready_policy == 0) ? 1'b1 : (ready_policy == 1) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 2) != 0);
      checks++;
      if (o_gen_valid !== 1'b1 || o_gen_data !== pat_byte(sel, n)) begin
        errors++;
        $display("FAIL %s_data n=%0d: valid=%b data=%h want 1 %h", tag, n, o_gen_valid, o_gen_data, pat_byte(sel, n));
      end
      if (!prev_rdy) begin
        checks++;
        if (o_gen_data !== prev_data) begin
          errors++;
          $display("FAIL %s_hold n=%0d: data=%h want %h", tag, n, o_gen_data, prev_data);
        end
      end
      checks++;
      if (o_byte_addr !== 10'(model_iter * PER + n) || o_page_last !== 1'((n % PB) == PB - 1) ||
          o_subsector_first !== 1'((n % SB) == 0)) begin
        errors++;
        $display("FAIL %s_addr n=%0d: addr=%0d pl=%b sf=%b want %0d %b %b", tag, n, o_byte_addr, o_page_last,
                 o_subsector_first, model_iter * PER + n, (n % PB) == PB - 1, (n % SB) == 0);
      end
      checks++;
      if (o_done !== 1'b0 || o_err_count !== 16'(model_err)) begin
        errors++;
        $display("FAIL %s_side n=%0d: done=%b err=%0d want 0 %0d", tag, n, o_done, o_err_count, model_err);
      end
      prev_data = o_gen_data;
      prev_rdy = rdy;
      i_gen_ready = rdy;
      @(negedge clk);
      if (rdy) n++;
      cyc++;
    end
    i_gen_ready = 1'b0;
    if (n < PER) begin
      errors++;
      $display("FAIL %s_timeout: transfers=%0d want %0d", tag, n, PER);
    end
    finish_iteration(tag);
  endtask

  // corrupt_mode: 0 = bytes 10 and 200 corrupted, 1 = random corruption
  task automatic test_check(input int sel, input bit random_valid, input int corrupt_mode);
    int n, cyc;
    logic v, bad;
    string tag;
    tag = $sformatf("chk_p%0d_c%0d", sel, corrupt_mode);
    start_run(1'b1, sel);
    n = 0; cyc = 0;
    while (n < PER && cyc < PER * 8) begin
      v   = random_valid ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      bad = (corrupt_mode == 0) ? 1'(n == 10 || n == 200) : 1'($urandom_range(0, 15) == 0);
      checks++;
      if (o_gen_valid !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_state n=%0d: valid=%b busy=%b done=%b want 0 1 0", tag, n, o_gen_valid, o_busy, o_done);
      end
      checks++;
      if (o_err_count !== 16'(model_err) || o_byte_addr !== 10'(model_iter * PER + n)) begin
        errors++;
        $display("FAIL %s_err n=%0d: err=%0d addr=%0d want %0d %0d", tag, n, o_err_count, o_byte_addr,
                 model_err, model_iter * PER + n);
      end
      i_gen_ready = 1'b1;
      i_chk_valid = v;
      i_chk_data  = pat_byte(sel, n) ^ (bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      @(negedge clk);
      if (v) begin
        if (bad) model_err++;
        n++;
      end
      cyc++;
    end
    i_chk_valid = 1'b0;
    i_gen_ready = 1'b0;
    if (n < PER) begin
      errors++;
      $display("FAIL %s_timeout: strobes=%0d want %0d", tag, n, PER);
    end
    checks++;
    if (o_err_count !== 16'(model_err)) begin
      errors++;
      $display("FAIL %s_final_err: err=%0d want %0d", tag, o_err_count, model_err);
    end
    if (corrupt_mode == 0) begin
      checks++;
      if (o_err_count !== 16'd2) begin
        errors++;
        $display("FAIL %s_two_errors: err=%0d want 2", tag, o_err_count);
      end
    end
    finish_iteration(tag);
  endtask

  task automatic test_abort();
    int n;
    start_run(1'b0, 2);
    n = 0;
    while (n < PER) begin
      checks++;
      if (o_gen_valid !== 1'b1 || o_gen_data !== pat_byte(2, n) || o_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_run n=%0d: valid=%b data=%h done=%b want 1 %h 0", n, o_gen_valid, o_gen_data,
                 o_done, pat_byte(2, n));
      end
      i_gen_ready = 1'b1;
      i_mode  = 1'b1;
      i_start = 1'(n == 50 || n == 100);
      i_abort = 1'(n == 100);
      @(negedge clk);
      if (n == 100) break;
      n++;
    end
    i_start = 1'b0; i_abort = 1'b0; i_gen_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_iter_idx !== 2'(model_iter) || o_err_count !== 16'(model_err)) begin
        errors++;
        $display("FAIL abort_idle c=%0d: busy=%b done=%b iter=%0d err=%0d want 0 0 %0d %0d", c, o_busy, o_done,
                 o_iter_idx, o_err_count, model_iter, model_err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int r = 0; r < 6; r++) begin
      sel = $urandom_range(0, PC - 1);
      if ($urandom_range(0, 1) == 1) test_check(sel, 1'b1, 1);
      else                           test_gen(sel, 2);
    end
  endtask

  task automatic test_iter_addresses();
    int cyc;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_iter = 0; model_err = 0;
    for (int r = 0; r < 5; r++) begin
      start_run(1'b0, r % PC);
      checks++;
      if (o_iter_start_addr !== 10'(model_iter * PER) || o_iter_idx !== 2'(model_iter) ||
          o_byte_addr !== 10'(model_iter * PER)) begin
        errors++;
        $display("FAIL iter_addr r=%0d: base=%0d iter=%0d addr=%0d want %0d %0d %0d", r, o_iter_start_addr,
                 o_iter_idx, o_byte_addr, model_iter * PER, model_iter, model_iter * PER);
      end
      i_gen_ready = 1'b1;
      cyc = 0;
      while (o_done !== 1'b1 && cyc < PER + 8) begin
        @(negedge clk);
        cyc++;
      end
      i_gen_ready = 1'b0;
      checks++;
      if (cyc != PER) begin
        errors++;
        $display("FAIL iter_len r=%0d: cycles=%0d want %0d", r, cyc, PER);
      end
      finish_iteration($sformatf("iter_r%0d", r));
    end
  endtask

  task automatic test_reset_mid_run();
    start_run(1'b1, 1);
    for (int i = 0; i < 5; i++) begin
      i_chk_valid = 1'b1;
      i_chk_data  = ~pat_byte(1, i);
      @(negedge clk);
    end
    i_chk_valid = 1'b0;
    checks++;
    if (o_err_count !== 16'd5 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_err: err=%0d busy=%b want 5 1", o_err_count, o_busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_gen_data, o_gen_valid, o_byte_addr, o_iter_start_addr, o_page_last, o_subsector_first,
         o_iter_idx, o_err_count, o_busy, o_done} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: data=%h addr=%0d base=%0d iter=%0d err=%0d busy=%b want all 0",
               o_gen_data, o_byte_addr, o_iter_start_addr, o_iter_idx, o_err_count, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    model_iter = 0; model_err = 0;
  endtask

`ifdef SF_TESTER_PATTERN_LFSR_EN
  task automatic test_lfsr();
    logic [7:0] want [4];
    want[0] = 8'hA5; want[1] = 8'h4B; want[2] = 8'h96; want[3] = 8'h2D;
    start_run(1'b0, PC);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_gen_valid !== 1'b1 || o_gen_data !== want[i]) begin
        errors++;
        $display("FAIL lfsr_byte%0d: valid=%b data=%h want 1 %h", i, o_gen_valid, o_gen_data, want[i]);
      end
      i_gen_ready = 1'b1;
      @(negedge clk);
    end
    i_gen_ready = 1'b0;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_gen(1, 0);
    test_gen(3, 1);
    test_check(0, 1'b0, 0);
    test_abort();
    test_random();
    test_iter_addresses();
    test_reset_mid_run();
`ifdef SF_TESTER_PATTERN_LFSR_EN
    test_lfsr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
